// File: rtl/wrr_lock_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wrr_lock_arbiter
//  Description : Weighted round-robin arbiter with burst locking; registered
//                one-hot grant held for up to weight[i] accepted beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module wrr_lock_arbiter #(
    parameter int REQ_WIDTH = 16,
    parameter int WEIGHT_W  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [REQ_WIDTH-1:0]          req,
    input  logic [REQ_WIDTH*WEIGHT_W-1:0] weight,
    input  logic                          lock,
    input  logic                          en,
    output logic [REQ_WIDTH-1:0]          gnt,
    output logic                          gnt_vld,
    output logic [$clog2(REQ_WIDTH)-1:0]  arb_port,
    output logic [WEIGHT_W-1:0]           credit
);

    localparam int PTR_W = $clog2(REQ_WIDTH);
    localparam logic [PTR_W-1:0]    c_last_port = PTR_W'(REQ_WIDTH - 1);
    localparam logic [WEIGHT_W-1:0] c_one       = WEIGHT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [REQ_WIDTH-1:0]  r_gnt;
    logic [PTR_W-1:0]      r_arb_port;
    logic [PTR_W-1:0]      r_ptr;
    logic [WEIGHT_W-1:0]   r_credit;

    state_t                w_state_nxt;
    logic [REQ_WIDTH-1:0]  w_gnt_nxt;
    logic [PTR_W-1:0]      w_port_nxt;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic [WEIGHT_W-1:0]   w_credit_nxt;

    logic [PTR_W-1:0]      w_owner_inc;
    logic [PTR_W-1:0]      w_start;
    logic [PTR_W-1:0]      w_pick_idx;
    logic [REQ_WIDTH-1:0]  w_pick_onehot;
    logic [WEIGHT_W-1:0]   w_pick_weight;
    logic [WEIGHT_W-1:0]   w_pick_weff;
    logic                  w_any_req;
    logic                  w_owner_req;
    logic                  w_gnt_vld;
    logic                  w_beat;
    logic                  w_release;

    assign w_any_req   = |req;
    assign w_owner_inc = (r_arb_port == c_last_port) ? '0 : r_arb_port + PTR_W'(1);
    // After a release the scan starts just past the old owner, which equals the new ptr
    assign w_start     = (r_state == S_IDLE) ? r_ptr : w_owner_inc;

    // Circular priority scan; iterating from the far end lets the nearest hit win
    always_comb begin
        int idx;
        w_pick_idx    = '0;
        w_pick_onehot = '0;
        w_pick_weight = '0;
        for (int k = REQ_WIDTH - 1; k >= 0; k--) begin
            idx = int'(w_start) + k;
            if (idx >= REQ_WIDTH) begin
                idx = idx - REQ_WIDTH;
            end
            if (req[idx]) begin
                w_pick_idx         = PTR_W'(idx);
                w_pick_onehot      = '0;
                w_pick_onehot[idx] = 1'b1;
                w_pick_weight      = weight[idx*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

    assign w_pick_weff = (w_pick_weight == '0) ? c_one : w_pick_weight;

    assign w_owner_req = req[r_arb_port];
    assign w_gnt_vld   = (r_state == S_OWN) && w_owner_req;
    assign w_beat      = w_gnt_vld && en;
    assign w_release   = !lock && ((w_beat && (r_credit == c_one)) || !w_owner_req);

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_port_nxt   = r_arb_port;
        w_ptr_nxt    = r_ptr;
        w_credit_nxt = r_credit;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt  = S_OWN;
                    w_gnt_nxt    = w_pick_onehot;
                    w_port_nxt   = w_pick_idx;
                    w_credit_nxt = w_pick_weff;
                end
            end
            S_OWN: begin
                if (w_release) begin
                    w_ptr_nxt = w_owner_inc;
                    if (w_any_req) begin
                        w_gnt_nxt    = w_pick_onehot;
                        w_port_nxt   = w_pick_idx;
                        w_credit_nxt = w_pick_weff;
                    end else begin
                        w_state_nxt  = S_IDLE;
                        w_gnt_nxt    = '0;
                        w_port_nxt   = '0;
                        w_credit_nxt = '0;
                    end
                end else if (w_beat && (r_credit > c_one)) begin
                    // A locked owner on its last credit keeps credit pinned at 1
                    w_credit_nxt = r_credit - c_one;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_gnt_nxt    = '0;
                w_port_nxt   = '0;
                w_credit_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_arb_port <= '0;
            r_ptr      <= '0;
            r_credit   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_arb_port <= w_port_nxt;
            r_ptr      <= w_ptr_nxt;
            r_credit   <= w_credit_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign gnt_vld  = w_gnt_vld;
    assign arb_port = r_arb_port;
    assign credit   = r_credit;

endmodule
`default_nettype wire

// File: tb/tb_wrr_lock_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wrr_lock_arbiter
//  Description : Self-checking bench for wrr_lock_arbiter with a behavioural
//                arbitration model plus directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wrr_lock_arbiter;

    localparam int N = 16;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] weight = '0;
    logic           lock = 1'b0;
    logic           en = 1'b0;
    logic [N-1:0]   gnt;
    logic           gnt_vld;
    logic [3:0]     arb_port;
    logic [W-1:0]   credit;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit m_own;
    int m_owner, m_cred, m_ptr;

    wrr_lock_arbiter #(.REQ_WIDTH(N), .WEIGHT_W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .weight   (weight),
        .lock     (lock),
        .en       (en),
        .gnt      (gnt),
        .gnt_vld  (gnt_vld),
        .arb_port (arb_port),
        .credit   (credit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic int weff(input logic [N*W-1:0] w, input int i);
        int f;
        f = int'((w >> (i * W)) & 64'hF);
        return (f == 0) ? 1 : f;
    endfunction

    task automatic compare();
        logic [N-1:0] exp_gnt;
        exp_gnt = m_own ? (N'(1) << m_owner) : '0;
        chk("gnt", gnt, exp_gnt);
        chk("gnt_vld", gnt_vld, m_own && req[m_owner]);
        if (m_own) begin
            chk("arb_port", arb_port, m_owner);
            chk("credit", credit, m_cred);
        end
    endtask

    task automatic model_step();
        bit vld, beat, rel;
        if (!m_own) begin
            if (req != 0) begin
                m_own   = 1;
                m_owner = pick(req, m_ptr);
                m_cred  = weff(weight, m_owner);
            end
        end else begin
            vld  = req[m_owner];
            beat = vld && en;
            rel  = !lock && ((beat && m_cred == 1) || !vld);
            if (rel) begin
                m_ptr = (m_owner + 1) % N;
                if (req != 0) begin
                    m_owner = pick(req, m_ptr);
                    m_cred  = weff(weight, m_owner);
                end else begin
                    m_own = 0;
                end
            end else if (beat && m_cred > 1) begin
                m_cred--;
            end
        end
    endtask

    // Called at posedge+1; inputs held until after the next posedge
    task automatic cyc(input logic [N-1:0] r, input logic l, input logic e);
        req  = r;
        lock = l;
        en   = e;
        @(negedge clk);
        compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_gnt_vld", gnt_vld, 0);
        chk("rst_arb_port", arb_port, 0);
        chk("rst_credit", credit, 0);
        m_own = 0; m_owner = 0; m_cred = 0; m_ptr = 0;
        req = '0; lock = 1'b0; en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] r;
        #1;
        do_reset();

        // T1: async reset in the middle of an ownership
        weight = {N{4'h1}};
        cyc(16'hFFFF, 0, 1);
        chk("t1_pre_gnt", gnt, 16'h0001);
        req = 16'hFFFF;
        do_reset();

        // T2: plain round robin, one beat each
        weight = {N{4'h1}};
        cyc(16'hFFFF, 0, 1);
        chk("t2_first", gnt, 16'h0001);
        for (int k = 1; k <= N; k++) begin
            cyc(16'hFFFF, 0, 1);
            chk("t2_rr_gnt", gnt, N'(1) << (k % N));
            chk("t2_rr_credit", credit, 1);
        end

        // T3: weight 3 vs 1
        do_reset();
        weight = 64'h13;
        begin
            logic [N-1:0] t3_g [8];
            logic [W-1:0] t3_c [8];
            t3_g = '{16'h1, 16'h1, 16'h1, 16'h2, 16'h1, 16'h1, 16'h1, 16'h2};
            t3_c = '{4'd3, 4'd2, 4'd1, 4'd1, 4'd3, 4'd2, 4'd1, 4'd1};
            for (int k = 0; k < 8; k++) begin
                cyc(16'h0003, 0, 1);
                chk("t3_gnt", gnt, t3_g[k]);
                chk("t3_credit", credit, t3_c[k]);
            end
        end

        // T4: backpressure stalls the turn
        do_reset();
        weight = {N{4'h2}};
        cyc(16'h0003, 0, 1);
        chk("t4_grant", credit, 2);
        cyc(16'h0003, 0, 1);
        chk("t4_beat1", credit, 1);
        cyc(16'h0003, 0, 0);
        chk("t4_stall_gnt", gnt, 16'h0001);
        chk("t4_stall_credit", credit, 1);
        cyc(16'h0003, 0, 1);
        chk("t4_switch", gnt, 16'h0002);
        chk("t4_switch_credit", credit, 2);

        // T5: lock pins owner 2 at credit 1
        do_reset();
        weight = 64'h100;
        cyc(16'h0006, 0, 1);
        chk("t5_own1", gnt, 16'h0002);
        cyc(16'h0006, 0, 1);
        chk("t5_own2", gnt, 16'h0004);
        for (int k = 0; k < 5; k++) begin
            cyc(16'h0006, 1, 1);
            chk("t5_locked_gnt", gnt, 16'h0004);
            chk("t5_locked_credit", credit, 1);
        end
        cyc(16'h0006, 0, 1);
        chk("t5_wrap_gnt", gnt, 16'h0002);
        chk("t5_wrap_port", arb_port, 1);

        // T6: owner drop to idle, then zero weight treated as one
        do_reset();
        weight = '0;
        cyc(16'h0020, 0, 1);
        chk("t6_own5", arb_port, 5);
        cyc(16'h0000, 0, 1);
        chk("t6_idle", gnt, 0);
        cyc(16'h0011, 0, 1);
        chk("t6_own0_gnt", gnt, 16'h0001);
        chk("t6_own0_credit", credit, 1);
        chk("t6_own0_port", arb_port, 0);

        // Randomized traffic against the model
        do_reset();
        r = '0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) weight = {$urandom, $urandom};
            if ($urandom_range(0, 31) == 0) r = '0;
            else r = r ^ N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 599) == 0) begin
                req = r;
                do_reset();
            end
            cyc(r, $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
